// File: rtl/bicubic_phase_arbiter.sv
// bicubic_phase_arbiter: shares one pipelined bicubic weight engine between the
// horizontal (H) and vertical (V) phase requesters. Round-robin grant, phase
// saturation to 1.0, a tag pipeline matched to the engine latency that routes
// each weight back to its requester, and a drain-gated reload of the `a` coefficient.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   h_req/h_phase/h_gnt        H requester (combinational grant)
//   v_req/v_phase/v_gnt        V requester (combinational grant)
//   cfg_a/cfg_load             pending `a` coefficient capture
//   eng_phase/eng_a/eng_result engine interface
//   res/h_rvalid/v_rvalid      returned weight and owner strobes
//   busy                       an accepted op has not yet returned
module bicubic_phase_arbiter #(
  parameter int LAT   = 6,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       h_req,
  input  logic [8:0] h_phase,
  output logic       h_gnt,
  input  logic       v_req,
  input  logic [8:0] v_phase,
  output logic       v_gnt,
  input  logic [8:0] cfg_a,
  input  logic       cfg_load,
  output logic [8:0] eng_phase,
  output logic [8:0] eng_a,
  input  logic [8:0] eng_result,
  output logic [8:0] res,
  output logic       h_rvalid,
  output logic       v_rvalid,
  output logic       busy
);

  localparam logic [8:0] PHASE_ONE = 9'd256;
  localparam logic [8:0] A_RESET   = 9'h080;

  logic             last_v_q, last_v_d;
  logic             pend_q, pend_d;
  logic [8:0]       pend_a_q, pend_a_d;
  logic [8:0]       eng_a_q, eng_a_d;
  logic [8:0]       eng_phase_q, eng_phase_d;
  logic [LAT:0]     tag_vld_q, tag_vld_d;
  logic [LAT:0]     tag_id_q, tag_id_d;
  logic [8:0]       res_q, res_d;
  logic             h_rvalid_q, h_rvalid_d;
  logic             v_rvalid_q, v_rvalid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic       h_win, v_win, acc, ret, commit;
  logic [8:0] sel_phase;

  always_comb begin
    // H wins unless V also requests and H took the previous grant.
    h_win     = h_req && (!v_req || last_v_q);
    v_win     = v_req && !h_win;
    h_gnt     = !pend_q && h_win;
    v_gnt     = !pend_q && v_win;
    acc       = h_gnt || v_gnt;
    sel_phase = h_gnt ? h_phase : v_phase;

    eng_phase_d = eng_phase_q;
    last_v_d    = last_v_q;
    if (acc) begin
      eng_phase_d = (sel_phase > PHASE_ONE) ? PHASE_ONE : sel_phase;
      last_v_d    = v_gnt;
    end

    // Stage 0 is loaded with the issuing op; the tail lines up with eng_result.
    tag_vld_d = {tag_vld_q[LAT-1:0], acc};
    tag_id_d  = {tag_id_q[LAT-1:0], v_gnt};

    res_d      = tag_vld_q[LAT] ? eng_result : res_q;
    h_rvalid_d = tag_vld_q[LAT] && !tag_id_q[LAT];
    v_rvalid_d = tag_vld_q[LAT] &&  tag_id_q[LAT];

    // An op leaves the in-flight count on its registered rvalid strobe.
    ret   = h_rvalid_q || v_rvalid_q;
    cnt_d = cnt_q;
    if (acc && !ret)      cnt_d = cnt_q + CNT_W'(1);
    else if (!acc && ret) cnt_d = cnt_q - CNT_W'(1);
    busy_d = (cnt_d != '0);

    // Grants are blocked while pending, so a zero count means the engine is
    // empty. A fresh cfg_load defers the commit by a cycle so the latest value wins.
    commit   = pend_q && (cnt_q == '0) && !cfg_load;
    pend_d   = cfg_load ? 1'b1 : (commit ? 1'b0 : pend_q);
    pend_a_d = cfg_load ? cfg_a : pend_a_q;
    eng_a_d  = commit ? pend_a_q : eng_a_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_v_q    <= 1'b1;
      pend_q      <= 1'b0;
      pend_a_q    <= '0;
      eng_a_q     <= A_RESET;
      eng_phase_q <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      res_q       <= '0;
      h_rvalid_q  <= 1'b0;
      v_rvalid_q  <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      last_v_q    <= last_v_d;
      pend_q      <= pend_d;
      pend_a_q    <= pend_a_d;
      eng_a_q     <= eng_a_d;
      eng_phase_q <= eng_phase_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      res_q       <= res_d;
      h_rvalid_q  <= h_rvalid_d;
      v_rvalid_q  <= v_rvalid_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign eng_phase = eng_phase_q;
  assign eng_a     = eng_a_q;
  assign res       = res_q;
  assign h_rvalid  = h_rvalid_q;
  assign v_rvalid  = v_rvalid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bicubic_phase_arbiter.sv
// tb_bicubic_phase_arbiter: directed stimulus for bicubic_phase_arbiter with a
// scoreboard of expected returns checked by an independent monitor.
// The engine model delays {eng_a, eng_phase} by LAT cycles and returns phase^0x1FF.
module tb_bicubic_phase_arbiter;

  localparam int LAT = 6;

  logic       clk, rst_n;
  logic       h_req, v_req, h_gnt, v_gnt, cfg_load;
  logic [8:0] h_phase, v_phase, cfg_a, eng_phase, eng_a, eng_result, res;
  logic       h_rvalid, v_rvalid, busy;

  bicubic_phase_arbiter #(.LAT(LAT), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .h_req(h_req), .h_phase(h_phase), .h_gnt(h_gnt),
    .v_req(v_req), .v_phase(v_phase), .v_gnt(v_gnt),
    .cfg_a(cfg_a), .cfg_load(cfg_load),
    .eng_phase(eng_phase), .eng_a(eng_a), .eng_result(eng_result),
    .res(res), .h_rvalid(h_rvalid), .v_rvalid(v_rvalid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model.
  typedef struct packed { logic [8:0] a; logic [8:0] ph; } eng_t;
  eng_t       pipe [LAT];
  logic [8:0] a_at_res;
  always @(posedge clk) begin
    pipe[0] <= {eng_a, eng_phase};
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    a_at_res <= pipe[LAT-1].a;
  end
  assign eng_result = pipe[LAT-1].ph ^ 9'h1FF;

  typedef struct { logic id; logic [8:0] res; logic [8:0] a; int cyc; } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_ph = 9'd0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h cyc=%0d", name, act, expv, cyc);
    end
  endtask

  function automatic logic [8:0] sat(input logic [8:0] p);
    return (p > 9'd256) ? 9'd256 : p;
  endfunction

  // Monitor: every rvalid must match the head of the scoreboard.
  always @(negedge clk) begin
    if (h_rvalid || v_rvalid) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rvalid h=%0b v=%0b cyc=%0d", h_rvalid, v_rvalid, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("rvalid_hv", {30'd0, h_rvalid, v_rvalid}, e.id ? 1 : 2);
        chk("res", res, e.res);
        chk("a_seen_by_op", a_at_res, e.a);
        chk("rvalid_cycle", cyc, e.cyc);
      end
    end
  end

  // One clock of stimulus; grants, eng_a and eng_phase checked every cycle.
  task automatic do_cycle(input logic hr, input logic [8:0] hp, input logic vr,
                          input logic [8:0] vp, input logic ld, input logic [8:0] ca,
                          input logic eh, input logic ev, input logic [8:0] ea);
    exp_t e;
    @(posedge clk);
    #1;
    h_req = hr; h_phase = hp; v_req = vr; v_phase = vp; cfg_load = ld; cfg_a = ca;
    @(negedge clk);
    chk("h_gnt", h_gnt, eh);
    chk("v_gnt", v_gnt, ev);
    chk("eng_a", eng_a, ea);
    chk("eng_phase", eng_phase, exp_ph);
    if (eh || ev) begin
      e.id  = ev;
      e.res = sat(eh ? hp : vp) ^ 9'h1FF;
      e.a   = ea;
      e.cyc = cyc + LAT + 2;
      sbq.push_back(e);
      exp_ph = sat(eh ? hp : vp);
    end
  endtask

  task automatic idle(input logic [8:0] ea);
    do_cycle(1'b0, 9'd0, 1'b0, 9'd0, 1'b0, 9'd0, 1'b0, 1'b0, ea);
  endtask

  task automatic check_reset_outputs();
    chk("rst_eng_phase", eng_phase, 0);
    chk("rst_res", res, 0);
    chk("rst_h_rvalid", h_rvalid, 0);
    chk("rst_v_rvalid", v_rvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_eng_a", eng_a, 9'h080);
  endtask

  initial begin
    int t0;
    rst_n = 1'b0;
    h_req = 1'b0; v_req = 1'b0; h_phase = '0; v_phase = '0; cfg_load = 1'b0; cfg_a = '0;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single H request: result 8 cycles after grant, V never strobed.
    do_cycle(1, 9'h040, 0, 9'd0, 0, 9'd0, 1, 0, 9'h080);
    repeat (10) idle(9'h080);

    // Saturation: 300 -> 256, 256 -> 256, 0 -> 0 (last one from V).
    do_cycle(1, 9'd300, 0, 9'd0, 0, 9'd0, 1, 0, 9'h080);
    do_cycle(1, 9'd256, 0, 9'd0, 0, 9'd0, 1, 0, 9'h080);
    do_cycle(0, 9'd0,   1, 9'd0, 0, 9'd0, 0, 1, 9'h080);
    repeat (10) idle(9'h080);

    // Tie held for 6 cycles after a V win: H,V,H,V,H,V.
    t0 = cyc + 1;
    for (int k = 0; k < 6; k++)
      do_cycle(1, 9'(16 + k), 1, 9'(200 + k), 0, 9'd0, (k % 2) == 0, (k % 2) == 1, 9'h080);
    while (cyc < t0 + 13) idle(9'h080);
    chk("busy_at_last_rvalid", busy, 1);
    idle(9'h080);
    chk("busy_after_last_rvalid", busy, 0);
    repeat (3) idle(9'h080);

    // Reload with 3 ops in flight: grants blocked until drained.
    do_cycle(1, 9'h010, 0, 9'd0, 0, 9'd0, 1, 0, 9'h080);
    do_cycle(1, 9'h020, 0, 9'd0, 0, 9'd0, 1, 0, 9'h080);
    do_cycle(1, 9'h030, 0, 9'd0, 0, 9'd0, 1, 0, 9'h080);
    do_cycle(0, 9'd0, 0, 9'd0, 1, 9'h0C0, 0, 0, 9'h080);
    for (int k = 4; k <= 12; k++)
      do_cycle(1, 9'h055, 0, 9'd0, 0, 9'd0, k >= 12, 0, (k >= 12) ? 9'h0C0 : 9'h080);
    repeat (12) idle(9'h0C0);

    // Two loads during one drain: single update straight to the latest value.
    do_cycle(1, 9'h0AA, 0, 9'd0, 0, 9'd0, 1, 0, 9'h0C0);
    for (int k = 1; k <= 12; k++)
      do_cycle(0, 9'd0, 0, 9'd0, k == 1 || k == 3, (k == 1) ? 9'h0A0 : 9'h0E0,
               0, 0, (k >= 10) ? 9'h0E0 : 9'h0C0);

    // Reset with 4 ops in flight: none may return.
    for (int k = 0; k < 4; k++)
      do_cycle(1, 9'(k * 8), 0, 9'd0, 0, 9'd0, 1, 0, 9'h0E0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    h_req = 1'b0; v_req = 1'b0; cfg_load = 1'b0;
    sbq.delete();
    exp_ph = 9'd0;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    repeat (12) idle(9'h080);
    do_cycle(1, 9'h011, 1, 9'h022, 0, 9'd0, 1, 0, 9'h080);
    do_cycle(0, 9'd0,   1, 9'h022, 0, 9'd0, 0, 1, 9'h080);

    for (int k = 0; k < 40 && sbq.size() != 0; k++) idle(9'h080);
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout outstanding=%0d expected=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bicubic_phase_arbiter.md
# bicubic_phase_arbiter

Shares one pipelined bicubic weight engine between a horizontal and a vertical phase requester in the scaler. Each accepted request drives the engine's blend-fraction and `a` inputs. A tag pipeline matched to the engine's fixed latency returns each weight to the requester that issued it. The `a` coefficient is reloaded only when the engine has drained.

## Interface
- `LAT`, 6: engine latency in cycles, from `eng_phase`/`eng_a` registered to `eng_result` valid. Must be ≥1.
- `CNT_W`, 4: in-flight counter width. Must satisfy 2^CNT_W > LAT+2.
- `clk`  in  1  clock; all logic rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `h_req`  in  1  horizontal request. Held with `h_phase` until granted.
- `h_phase`  in  9  horizontal blend fraction, Q1.8 (256 = 1.0).
- `h_gnt`  out  1  combinational grant. Request accepted in any cycle where `h_req && h_gnt`.
- `v_req`, `v_phase`, `v_gnt`: same as the horizontal set, for the vertical requester.
- `cfg_a`  in  9  new `a` coefficient, Q1.8.
- `cfg_load`  in  1  single-cycle pulse. Captures `cfg_a` as pending.
- `eng_phase`  out  9  registered blend fraction to the engine.
- `eng_a`  out  9  active `a` coefficient to the engine.
- `eng_result`  in  9  engine weight output.
- `res`  out  9  registered returned weight.
- `h_rvalid` / `v_rvalid`  out  1  one-cycle strobes marking `res` as belonging to H or V.
- `busy`  out  1  high while any accepted request has not yet produced its rvalid.

## Operation
- **Reset values:**
  - Outputs: `eng_phase`=0, `res`=0, rvalids=0, `busy`=0.
  - `eng_a`=0x080 (0.5).
  - Pending flag = 0; tag pipeline all invalid; last-winner = V, so H wins the first tie.
- **Grant rules:**
  - A grant requires the pending flag to be clear.
  - One requester requesting: it is granted.
  - Both requesting: round-robin. The one that did not win the last grant wins.
  - Last-winner updates only on an accepted request.
  - At most one grant per cycle. Throughput is 1 op/cycle.
- **Issue:** on acceptance, `eng_phase` is registered with the winner's phase, saturated at 256 (phase > 256 becomes 256).
- **Tag pipeline:**
  - Depth LAT+1 shift register of {valid, id}, where id 0 = H and 1 = V.
  - Loaded on acceptance; shifts every cycle.
  - When the tail entry is valid: `res` <= `eng_result`, and the matching rvalid is pulsed for one cycle.
- **In-flight counter:**
  - +1 on acceptance, −1 on an rvalid strobe; both in the same cycle = no change.
  - `busy` = (count ≠ 0), registered.
- **Config reload:**
  - `cfg_load` sets the pending flag and stores `cfg_a`.
  - While pending, both grants are 0.
  - In the first cycle with count = 0 and pending set: `eng_a` <= stored value, pending cleared. Grants resume the next cycle.
  - A second `cfg_load` while pending overwrites the stored value. The latest one wins.
  - `cfg_load` in the same cycle as an acceptance: the acceptance completes, then the reload waits for the drain.
- **Reset mid-operation:** all in-flight tags are discarded. No rvalid is emitted for ops issued before reset.

## Timing
- Request accepted in cycle T.
- `eng_phase` valid at T+1.
- `eng_result` valid at T+1+LAT.
- `res`/rvalid at T+2+LAT.
- Grant-to-result latency is LAT+2 cycles, fixed and independent of contention.
- `eng_a` changes only while count = 0. No op ever sees a mid-flight change of `a`.
- Reload stall:
  - Last op accepted at T, `cfg_load` at T+1.
  - rvalid at T+LAT+2, so count = 0 from T+LAT+3.
  - `eng_a` updated at T+LAT+4.
  - First new grant at T+LAT+4.

## Test plan
- Single H request, phase 0x040, engine model returning `phase^0x1FF`, LAT=6 → `h_rvalid` 8 cycles after grant, `res`=0x1BF, `v_rvalid` never asserted.
- H and V both held requesting for 6 cycles → grants alternate H,V,H,V,H,V; rvalids alternate in the same order with no gaps; `busy` drops 1 cycle after the last rvalid.
- `h_phase`=300 → `eng_phase`=256. `h_phase`=256 → 256. `h_phase`=0 → 0.
- `cfg_load` with `cfg_a`=0x0C0 while 3 ops are in flight → no grant until drained; `eng_a`=0x0C0 exactly 1 cycle after count hits 0; earlier ops all return with `eng_a` still 0x080.
- Two `cfg_load` pulses (0x0A0 then 0x0E0) during a drain → `eng_a` ends at 0x0E0, with a single update.
- `rst_n` asserted with 4 ops in flight, released 2 cycles later → no rvalid for those ops; all outputs at reset values; `eng_a`=0x080; next H/V tie grants H.
